// File: rtl/leve1_csr_exec_pkg.sv
// Shared constants and types for the execute-stage CSR unit.
package leve1_csr_exec_pkg;

    localparam int XLEN_DEF = 64;

    // CSR file write command encoding
    localparam logic [1:0] CSR_NONE  = 2'd0;
    localparam logic [1:0] CSR_WRITE = 2'd1;
    localparam logic [1:0] CSR_SET   = 2'd2;
    localparam logic [1:0] CSR_CLEAR = 2'd3;

    // Privilege levels
    localparam logic [1:0] MODE_U = 2'd0;
    localparam logic [1:0] MODE_S = 2'd1;
    localparam logic [1:0] MODE_M = 2'd3;

    localparam int EXC_ILLEGAL_INST = 2;

    // funct3 of the SYSTEM/CSR instruction group
    localparam logic [2:0] F3_CSRRW  = 3'd1;
    localparam logic [2:0] F3_CSRRS  = 3'd2;
    localparam logic [2:0] F3_CSRRC  = 3'd3;
    localparam logic [2:0] F3_CSRRWI = 3'd5;
    localparam logic [2:0] F3_CSRRSI = 3'd6;
    localparam logic [2:0] F3_CSRRCI = 3'd7;

    typedef enum logic [1:0] {
        CSRX_IDLE = 2'd0,
        CSRX_READ = 2'd1,
        CSRX_RESP = 2'd2,
        CSRX_EXC  = 2'd3
    } csrx_state_e;

endpackage

// File: rtl/leve1_csr_legal.sv
// Combinational legality check and write-command decode for one CSR access.
module leve1_csr_legal
    import leve1_csr_exec_pkg::*;
(
    input  logic [11:0] CSR,
    input  logic [2:0]  FUNCT3,
    input  logic        NOWR,
    input  logic [1:0]  MODE,
    output logic        ILLEGAL,
    output logic [1:0]  WCMD
);

    // Illegal on bad funct3, insufficient privilege, or a write to a read-only CSR
    always_comb begin
        ILLEGAL = (FUNCT3[1:0] == 2'b00)
               || (CSR[9:8] > MODE)
               || ((CSR[11:10] == 2'b11) && !NOWR);
    end

    // Register and immediate forms share an operation; pure reads issue no write
    always_comb begin
        WCMD = CSR_NONE;
        if (!NOWR) begin
            case (FUNCT3)
                F3_CSRRW, F3_CSRRWI: WCMD = CSR_WRITE;
                F3_CSRRS, F3_CSRRSI: WCMD = CSR_SET;
                F3_CSRRC, F3_CSRRCI: WCMD = CSR_CLEAR;
                default:             WCMD = CSR_NONE;
            endcase
        end
    end

endmodule

// File: rtl/leve1_csr_exec.sv
// Execute-stage CSR instruction unit: reads the CSR file, checks legality,
// issues the write command, and returns the old value or an exception.
module leve1_csr_exec
    import leve1_csr_exec_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int ILL_CAUSE = EXC_ILLEGAL_INST
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [1:0]      MODE,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [2:0]      REQ_FUNCT3,
    input  logic [11:0]     REQ_CSR,
    input  logic [4:0]      REQ_RS1,
    input  logic [XLEN-1:0] REQ_RS1_VAL,
    input  logic [4:0]      REQ_RD,
    input  logic            FLUSH,
    output logic [11:0]     CSR_RA,
    input  logic [XLEN-1:0] CSR_RD,
    output logic [1:0]      CSR_WCMD,
    output logic [11:0]     CSR_WA,
    output logic [XLEN-1:0] CSR_WD,
    output logic            RETIRE,
    output logic            WB_VALID,
    input  logic            WB_READY,
    output logic [4:0]      WB_RD,
    output logic [XLEN-1:0] WB_DATA,
    output logic            EXC_VALID,
    output logic [XLEN-1:0] EXC_CAUSE
);

    csrx_state_e     state_q, state_d;
    logic [2:0]      f3_q;
    logic [11:0]     csr_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] op_q;
    logic [XLEN-1:0] wb_data_q;
    logic            nowr_q;
    logic            first_q;
    logic            illegal;
    logic [1:0]      wcmd;
    logic            accept;

    assign accept = (state_q == CSRX_IDLE) && REQ_VALID && !FLUSH;

    leve1_csr_legal u_legal (
        .CSR     (csr_q),
        .FUNCT3  (f3_q),
        .NOWR    (nowr_q),
        .MODE    (MODE),
        .ILLEGAL (illegal),
        .WCMD    (wcmd)
    );

    // State register; reset drops any in-flight instruction
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= CSRX_IDLE;
        else       state_q <= state_d;
    end

    // Capture the instruction on accept, old CSR value in READ, first-RESP flag
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            f3_q      <= '0;
            csr_q     <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            nowr_q    <= 1'b0;
            wb_data_q <= '0;
            first_q   <= 1'b0;
        end else begin
            if (accept) begin
                f3_q   <= REQ_FUNCT3;
                csr_q  <= REQ_CSR;
                rd_q   <= REQ_RD;
                op_q   <= REQ_FUNCT3[2] ? {{(XLEN-5){1'b0}}, REQ_RS1} : REQ_RS1_VAL;
                nowr_q <= REQ_FUNCT3[1] && (REQ_RS1 == 5'd0);
            end
            if (state_q == CSRX_READ) begin
                wb_data_q <= CSR_RD;
                first_q   <= 1'b1;
            end else if (state_q == CSRX_RESP) begin
                first_q   <= 1'b0;
            end
        end
    end

    // Next-state and handshake/command outputs
    always_comb begin
        state_d   = state_q;
        REQ_READY = 1'b0;
        CSR_RA    = csr_q;
        CSR_WCMD  = CSR_NONE;
        WB_VALID  = 1'b0;
        RETIRE    = 1'b0;
        EXC_VALID = 1'b0;
        EXC_CAUSE = '0;
        case (state_q)
            CSRX_IDLE: begin
                // Address goes straight through so the file samples it at the accepting edge
                REQ_READY = !FLUSH;
                CSR_RA    = REQ_CSR;
                if (accept) state_d = CSRX_READ;
            end
            CSRX_READ: begin
                if (FLUSH)        state_d = CSRX_IDLE;
                else if (illegal) state_d = CSRX_EXC;
                else begin
                    CSR_WCMD = wcmd;
                    state_d  = CSRX_RESP;
                end
            end
            CSRX_RESP: begin
                // Write already committed, so FLUSH no longer matters here
                WB_VALID = 1'b1;
                RETIRE   = first_q;
                if (WB_READY) state_d = CSRX_IDLE;
            end
            CSRX_EXC: begin
                EXC_VALID = 1'b1;
                EXC_CAUSE = XLEN'(ILL_CAUSE);
                state_d   = CSRX_IDLE;
            end
            default: state_d = CSRX_IDLE;
        endcase
    end

    assign CSR_WA  = csr_q;
    assign CSR_WD  = op_q;
    assign WB_RD   = rd_q;
    assign WB_DATA = wb_data_q;

endmodule
